// File: rtl/sdram_row_scheduler.sv
// sdram_row_scheduler: arbitrates display fetch, capture writeback and refresh onto one SDRAM command port.
//
// Ports:
//   clk, reset_n            system clock, synchronous active-low reset
//   g_req / g_ack           display toggle handshake (pending while g_req ^ g_ack)
//   g_cache_row, g_sdram_row  display line-cache half and SDRAM row to read
//   c_req / c_ack           capture toggle handshake (pending while c_req ^ c_ack)
//   c_cache_row, c_sdram_row  capture-buffer half and SDRAM row to write
//   cmd_valid / cmd_ready   command handshake to the SDRAM controller
//   cmd_op                  0 = read, 1 = write, 2 = refresh
//   cmd_sdram_row, cmd_cache_row  fields of the offered command
//   cmd_done                one-cycle pulse when the accepted command finishes
// Optional build macro SCHED_STATS_EN adds parameter DISP_DEADLINE, input stat_clear
// and output stat_late (saturating count of display requests acked late).
module sdram_row_scheduler #(
    parameter int REFRESH_INTERVAL = 780,
    parameter int REFRESH_MAX = 4
`ifdef SCHED_STATS_EN
    , parameter int DISP_DEADLINE = 1200
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       g_req,
    output logic       g_ack,
    input  logic       g_cache_row,
    input  logic [9:0] g_sdram_row,
    input  logic       c_req,
    output logic       c_ack,
    input  logic       c_cache_row,
    input  logic [9:0] c_sdram_row,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] cmd_op,
    output logic [9:0] cmd_sdram_row,
    output logic       cmd_cache_row,
    input  logic       cmd_done
`ifdef SCHED_STATS_EN
    , input  logic        stat_clear
    , output logic [15:0] stat_late
`endif
);
    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    localparam logic [1:0] OP_READ = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_REFRESH = 2'd2;
    localparam int TW = $clog2(REFRESH_INTERVAL);
    localparam logic [TW-1:0] T_LAST = TW'(REFRESH_INTERVAL - 1);
    localparam logic [2:0] R_MAX = 3'(REFRESH_MAX);

    state_t state, next_state;
    logic [TW-1:0] timer;
    logic [2:0] debt;
    logic [1:0] skip;
    logic g_pend, c_pend, starve, grant, wrap, ref_done;
    logic [1:0] grant_op;

    always_comb begin
        g_pend = g_req ^ g_ack;
        c_pend = c_req ^ c_ack;
        starve = skip == 2'd3;
        wrap = timer == T_LAST;
        ref_done = state == DONE && cmd_op == OP_REFRESH;
        grant = state == IDLE && (debt != 3'd0 || g_pend || c_pend);
        // starved capture jumps ahead of ordinary refresh, never ahead of display or urgent refresh
        grant_op = debt >= R_MAX       ? OP_REFRESH :
                   g_pend              ? OP_READ    :
                   (starve && c_pend)  ? OP_WRITE   :
                   debt != 3'd0        ? OP_REFRESH : OP_WRITE;
        next_state = state;
        case (state)
            IDLE:  next_state = grant ? ISSUE : IDLE;
            ISSUE: next_state = cmd_ready ? BUSY : ISSUE;
            BUSY:  next_state = cmd_done ? DONE : BUSY;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            timer <= '0;
            debt <= '0;
            skip <= '0;
            g_ack <= 1'b0;
            c_ack <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_op <= OP_READ;
            cmd_sdram_row <= '0;
            cmd_cache_row <= 1'b0;
        end else begin
            state <= next_state;
            cmd_valid <= next_state == ISSUE;
            timer <= wrap ? '0 : timer + 1'b1;
            if (wrap && !ref_done && debt != 3'd7)
                debt <= debt + 3'd1;
            else if (ref_done && !wrap)
                debt <= debt - 3'd1;
            if (grant) begin
                cmd_op <= grant_op;
                cmd_sdram_row <= grant_op == OP_READ ? g_sdram_row : grant_op == OP_WRITE ? c_sdram_row : '0;
                cmd_cache_row <= grant_op == OP_READ ? g_cache_row : grant_op == OP_WRITE && c_cache_row;
                skip <= grant_op == OP_WRITE ? 2'd0 : (c_pend && !starve) ? skip + 2'd1 : skip;
            end
            if (state == DONE) begin
                g_ack <= g_ack ^ (cmd_op == OP_READ);
                c_ack <= c_ack ^ (cmd_op == OP_WRITE);
            end
        end
    end

`ifdef SCHED_STATS_EN
    localparam int AW = $clog2(DISP_DEADLINE + 2);
    localparam logic [AW-1:0] AGE_LATE = AW'(DISP_DEADLINE + 1);
    logic [AW-1:0] g_age;

    // g_age counts clocks the display request has been pending, parked once it is already late
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            g_age <= '0;
            stat_late <= '0;
        end else begin
            g_age <= !g_pend ? '0 : g_age == AGE_LATE ? g_age : g_age + 1'b1;
            if (stat_clear)
                stat_late <= '0;
            else if (state == DONE && cmd_op == OP_READ && g_age == AGE_LATE && stat_late != 16'hFFFF)
                stat_late <= stat_late + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sdram_row_scheduler.sv
// tb_sdram_row_scheduler: directed vector and sequence bench for sdram_row_scheduler.
module tb_sdram_row_scheduler;
    logic clk = 1'b0, reset_n = 1'b0;
    logic g_req = 1'b0, g_cache_row = 1'b0, c_req = 1'b0, c_cache_row = 1'b0;
    logic cmd_ready = 1'b0, cmd_done = 1'b0;
    logic [9:0] g_sdram_row = '0, c_sdram_row = '0, cmd_sdram_row;
    logic g_ack, c_ack, cmd_valid, cmd_cache_row;
    logic [1:0] cmd_op;
`ifdef SCHED_STATS_EN
    logic stat_clear = 1'b0;
    logic [15:0] stat_late;
`endif
    int total = 0, bad = 0, done_delay = 1, cnt = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic g_req; logic [9:0] g_row; logic g_half;
        logic c_req; logic [9:0] c_row; logic c_half;
        logic ready;
        logic e_gack; logic e_cack; logic e_valid; logic [1:0] e_op; logic [9:0] e_row; logic e_half;
    } vec_t;
    vec_t v[13];

    sdram_row_scheduler #(
        .REFRESH_INTERVAL(40),
        .REFRESH_MAX(4)
`ifdef SCHED_STATS_EN
        , .DISP_DEADLINE(10)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .g_req(g_req), .g_ack(g_ack), .g_cache_row(g_cache_row), .g_sdram_row(g_sdram_row),
        .c_req(c_req), .c_ack(c_ack), .c_cache_row(c_cache_row), .c_sdram_row(c_sdram_row),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_sdram_row(cmd_sdram_row), .cmd_cache_row(cmd_cache_row), .cmd_done(cmd_done)
`ifdef SCHED_STATS_EN
        , .stat_clear(stat_clear), .stat_late(stat_late)
`endif
    );

    always #5 clk = ~clk;

    // Controller model: a falling cmd_valid marks an accept; cmd_done is sampled done_delay edges later.
    initial forever begin
        @(posedge clk);
        #1;
        cmd_done = 1'b0;
        if (prev_valid && !cmd_valid) cnt = done_delay;
        if (cnt > 0) begin
            if (cnt == 1) cmd_done = 1'b1;
            cnt--;
        end
        prev_valid = cmd_valid;
    end

    function automatic logic [15:0] outs();
        return {g_ack, c_ack, cmd_valid, cmd_op, cmd_sdram_row, cmd_cache_row};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        g_req = 1'b0;
        c_req = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        v[0]  = '{1'b1, 10'h05A, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 10'h05A, 1'b1};
        v[1]  = '{1'b1, 10'h05A, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 10'h05A, 1'b1};
        v[2]  = '{1'b1, 10'h05A, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 10'h05A, 1'b1};
        v[3]  = '{1'b1, 10'h05A, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 10'h05A, 1'b1};
        v[4]  = '{1'b0, 10'h123, 1'b0, 1'b1, 10'h2AB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 10'h123, 1'b0};
        v[5]  = '{1'b0, 10'h123, 1'b0, 1'b1, 10'h2AB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 10'h123, 1'b0};
        v[6]  = '{1'b0, 10'h123, 1'b0, 1'b1, 10'h2AB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 10'h123, 1'b0};
        v[7]  = '{1'b0, 10'h123, 1'b0, 1'b1, 10'h2AB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 10'h123, 1'b0};
        v[8]  = '{1'b0, 10'h123, 1'b0, 1'b1, 10'h2AB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 10'h2AB, 1'b1};
        v[9]  = '{1'b0, 10'h123, 1'b0, 1'b1, 10'h2AB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 10'h2AB, 1'b1};
        v[10] = '{1'b0, 10'h123, 1'b0, 1'b1, 10'h2AB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 10'h2AB, 1'b1};
        v[11] = '{1'b0, 10'h123, 1'b0, 1'b1, 10'h2AB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 10'h2AB, 1'b1};
        v[12] = '{1'b0, 10'h123, 1'b0, 1'b1, 10'h2AB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 10'h2AB, 1'b1};

        do_reset();
        chk("reset_outputs", 32'(outs()), 32'h0);
        chk("reset_debt", 32'(dut.debt), 32'h0);

        // single display read, then display and capture pending together
        for (int i = 0; i < 13; i++) begin
            g_req = v[i].g_req; g_sdram_row = v[i].g_row; g_cache_row = v[i].g_half;
            c_req = v[i].c_req; c_sdram_row = v[i].c_row; c_cache_row = v[i].c_half;
            cmd_ready = v[i].ready;
            step();
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({v[i].e_gack, v[i].e_cack, v[i].e_valid, v[i].e_op, v[i].e_row, v[i].e_half}));
        end
`ifdef SCHED_STATS_EN
        chk("stat_on_time", 32'(stat_late), 32'h0);
`endif

        // capture held in ISSUE by cmd_ready low, then a one-cycle reset
        c_req = 1'b0; c_sdram_row = 10'h3C3; c_cache_row = 1'b0; cmd_ready = 1'b0;
        step();
        chk("stall_grant", 32'(outs()), 32'({1'b0, 1'b1, 1'b1, 2'd1, 10'h3C3, 1'b0}));
        for (int i = 0; i < 50; i++) begin
            step();
            chk($sformatf("stall%0d", i), 32'(outs()), 32'({1'b0, 1'b1, 1'b1, 2'd1, 10'h3C3, 1'b0}));
        end
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mid_reset", 32'(outs()), 32'h0);

        // refresh debt builds while display is busy; refresh preempts, then starved capture wins
        do_reset();
        g_req = 1'b1; g_sdram_row = 10'h1A1; g_cache_row = 1'b0;
        c_req = 1'b1; c_sdram_row = 10'h0F0; c_cache_row = 1'b1;
        cmd_ready = 1'b1; done_delay = 163;
        step();
        chk("disp_grant", 32'({cmd_valid, cmd_op}), 32'({1'b1, 2'd0}));
        step(2);
        done_delay = 1;
        step(161);
        chk("debt_full", 32'({dut.debt, cmd_valid, g_ack}), 32'({3'd4, 1'b0, 1'b0}));
        step(2);
        chk("disp_ack", 32'(g_ack), 32'h1);
        step();
        chk("urgent_refresh", 32'({cmd_valid, cmd_op}), 32'({1'b1, 2'd2}));
        step(3);
        chk("debt_after_ref", 32'(dut.debt), 32'd3);
        step();
        chk("second_refresh", 32'({cmd_valid, cmd_op}), 32'({1'b1, 2'd2}));
        step(3);
        chk("debt_after_ref2", 32'(dut.debt), 32'd2);
        step();
        chk("starved_capture", 32'({cmd_valid, cmd_op, cmd_sdram_row, cmd_cache_row}),
            32'({1'b1, 2'd1, 10'h0F0, 1'b1}));
        step(3);
        chk("capture_ack", 32'({g_ack, c_ack}), 32'({1'b1, 1'b1}));
        step();
        chk("refresh_after_cap", 32'({cmd_valid, cmd_op}), 32'({1'b1, 2'd2}));

`ifdef SCHED_STATS_EN
        do_reset();
        done_delay = 20;
        g_req = 1'b1;
        step(30);
        chk("late_ack", 32'(g_ack), 32'h1);
        chk("stat_late", 32'(stat_late), 32'h1);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        chk("stat_clear", 32'(stat_late), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdram_row_scheduler.md
# sdram_row_scheduler

Arbiter and sequencer for the single SDRAM command port shared by the display line-cache fetch, the capture-side row writeback and periodic refresh. It takes toggle-style requests (pending while `req != ack`) from the VGA frame generator and the capture path and issues one whole-row command at a time to the SDRAM controller. It owns the refresh timer and acknowledges each requester only after its row transfer has completed.

## Interface
- `REFRESH_INTERVAL`, 780: clocks between refresh credits.
- `REFRESH_MAX`, 4: owed-refresh debt at which refresh preempts display.
- `DISP_DEADLINE`, 1200: clocks a display request may stay pending before it counts as late.

- `clk` in 1: system clock. Same clock as the frame generator.
- `reset_n` in 1: reset, synchronous and active-low.
- `g_req` in 1: display fetch request toggle.
- `g_ack` out 1: display ack toggle.
- `g_cache_row` in 1: line-cache half to fill.
- `g_sdram_row` in 10: SDRAM row to read.
- `c_req` in 1: capture writeback request toggle.
- `c_ack` out 1: capture ack toggle.
- `c_cache_row` in 1: capture-buffer half to drain.
- `c_sdram_row` in 10: SDRAM row to write.
- `cmd_valid` out 1: command offered.
- `cmd_ready` in 1: controller accepts the command.
- `cmd_op` out 2: 0 = read, 1 = write, 2 = refresh.
- `cmd_sdram_row` out 10: row for the command.
- `cmd_cache_row` out 1: cache or buffer half for the command.
- `cmd_done` in 1: one-cycle pulse when the accepted command has finished.

## Operation
- A request is pending while `req ^ ack` is 1.
- Request fields are captured into command registers at grant. Requesters hold them stable until acked.
- Refresh debt counter, 3 bits:
  - Credit timer counts 0 to `REFRESH_INTERVAL`-1; each wrap increments debt, saturating at 7.
  - A completed refresh decrements debt.
  - A wrap and a refresh completion in the same cycle leave debt unchanged.
- State machine:
  - IDLE: evaluates the grant.
  - ISSUE: `cmd_valid`=1, fields constant; moves to BUSY on `cmd_ready`.
  - BUSY: waits for `cmd_done`.
  - DONE: toggles the owning ack (or decrements debt for refresh), then returns to IDLE.
- Grant priority in IDLE, fixed:
  1. Refresh if debt ≥ `REFRESH_MAX`.
  2. Display if pending.
  3. Refresh if debt > 0.
  4. Capture if pending.
  5. Otherwise stay in IDLE.
- Anti-starvation: after 3 consecutive grants that skipped a pending capture, capture moves above item 3, once. The counter clears whenever capture is granted.
- `cmd_done` outside BUSY is ignored.
- A requester changing its fields or toggling `req` again while its command is in flight is a protocol violation and is ignored until its ack.
- Reset during any state returns to IDLE on the next edge. Any in-flight transaction is abandoned without ack.

## Timing
- Reset values:
  - `g_ack`=0, `c_ack`=0, `cmd_valid`=0.
  - `cmd_op`=0, `cmd_sdram_row`=0, `cmd_cache_row`=0.
  - State IDLE, debt 0, credit timer 0, skip counter 0.
- A request visible in IDLE at edge N is granted at edge N and gives `cmd_valid`=1 from edge N+1.
- `cmd_valid` deasserts at the edge after the `cmd_ready` sample. A same-cycle ISSUE→BUSY with `cmd_done` is not possible.
- `cmd_done` sampled at edge M toggles the ack at edge M+1, via DONE. IDLE is reached at M+2.
- Minimum request-to-ack latency with `cmd_ready`=1 and `cmd_done` immediate is 4 clocks.
- All outputs are registered. No combinational path from any input to any output.

## Configuration
- `SCHED_STATS_EN` defined:
  - Adds output `stat_late` [15:0] and input `stat_clear`.
  - `stat_late` counts display requests acked more than `DISP_DEADLINE` clocks after first seen pending, saturating at 16'hFFFF.
  - `stat_clear`=1 zeroes it. Clear has priority over an increment in the same cycle.
  - Reset value 0.
- Undefined: neither port exists and no deadline logic is synthesized. Arbitration is identical in both builds.

## Test plan
- Reset, then `g_req`=1 with row 10'h05A, half 1, `cmd_ready`=1, `cmd_done` one cycle after accept: `cmd_op`=0, row 5A, half 1; `g_ack`=1 four clocks after the request.
- Display and capture pending in the same cycle, debt 0: display is issued first; capture is issued immediately after the display DONE; acks toggle in that order.
- Hold display busy so that debt reaches 4 with both requesters pending: the next grant is `cmd_op`=2; debt reads 3 after `cmd_done`.
- Capture pending while display and refresh win 3 consecutive grants: the 4th grant goes to capture despite debt > 0.
- `cmd_ready` held low for 50 clocks in ISSUE: `cmd_valid` and fields remain constant; no ack changes; `reset_n`=0 for one cycle returns all outputs to their reset values.
- With `SCHED_STATS_EN`, `DISP_DEADLINE`=10, and `cmd_done` delayed 20 clocks: `stat_late` becomes 1; `stat_clear` pulse returns it to 0.
